// File: rtl/image_ycbcr444_rgb888.sv
// YCbCr 4:4:4 to RGB888/RGB565 converter, 3-clk free-running pipeline.
// Define YCBCR_FULL_RANGE_EN for JPEG full-range coefficients (default: BT.601 studio range).
module image_ycbcr444_rgb888 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_Y,
  input  logic [7:0]  per_img_Cb,
  input  logic [7:0]  per_img_Cr,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [7:0]  post_img_R,
  output logic [7:0]  post_img_G,
  output logic [7:0]  post_img_B,
  output logic [15:0] post_img_RGB565
);

`ifdef YCBCR_FULL_RANGE_EN
  localparam logic signed [20:0] KY    = 21'sd512;
  localparam logic signed [20:0] KRV   = 21'sd718;
  localparam logic signed [20:0] KGU   = 21'sd176;
  localparam logic signed [20:0] KGV   = 21'sd366;
  localparam logic signed [20:0] KBU   = 21'sd907;
  localparam logic signed [9:0]  Y_OFF = 10'sd0;
`else
  localparam logic signed [20:0] KY    = 21'sd596;
  localparam logic signed [20:0] KRV   = 21'sd817;
  localparam logic signed [20:0] KGU   = 21'sd201;
  localparam logic signed [20:0] KGV   = 21'sd416;
  localparam logic signed [20:0] KBU   = 21'sd1033;
  localparam logic signed [9:0]  Y_OFF = 10'sd16;
`endif

  localparam logic signed [20:0] ROUND = 21'sd256;

  // Stage 1: offset removal and coefficient products
  logic signed [9:0]  y_s;
  logic signed [8:0]  cb_s;
  logic signed [8:0]  cr_s;
  logic signed [20:0] ky_y, krv_cr, kgu_cb, kgv_cr, kbu_cb;

  always_comb begin
    y_s    = $signed({2'b00, per_img_Y}) - Y_OFF;
    cb_s   = $signed({1'b0, per_img_Cb}) - 9'sd128;
    cr_s   = $signed({1'b0, per_img_Cr}) - 9'sd128;
    ky_y   = KY  * 21'(y_s);
    krv_cr = KRV * 21'(cr_s);
    kgu_cb = KGU * 21'(cb_s);
    kgv_cr = KGV * 21'(cr_s);
    kbu_cb = KBU * 21'(cb_s);
  end

  logic signed [20:0] ky_y_r, krv_cr_r, kgu_cb_r, kgv_cr_r, kbu_cb_r;
  logic signed [20:0] r_sum, g_sum, b_sum;
  logic [2:0]         vsync_sr, href_sr, clken_sr;

  function automatic logic [7:0] clamp8(input logic signed [20:0] s);
    logic signed [20:0] q;
    q = s >>> 9;
    if (q < 21'sd0)        return 8'd0;
    else if (q > 21'sd255) return 8'd255;
    else                   return q[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ky_y_r     <= '0;
      krv_cr_r   <= '0;
      kgu_cb_r   <= '0;
      kgv_cr_r   <= '0;
      kbu_cb_r   <= '0;
      r_sum      <= '0;
      g_sum      <= '0;
      b_sum      <= '0;
      post_img_R <= '0;
      post_img_G <= '0;
      post_img_B <= '0;
      vsync_sr   <= '0;
      href_sr    <= '0;
      clken_sr   <= '0;
    end else begin
      ky_y_r   <= ky_y;
      krv_cr_r <= krv_cr;
      kgu_cb_r <= kgu_cb;
      kgv_cr_r <= kgv_cr;
      kbu_cb_r <= kbu_cb;

      r_sum <= ky_y_r + krv_cr_r + ROUND;
      g_sum <= ky_y_r - kgu_cb_r - kgv_cr_r + ROUND;
      b_sum <= ky_y_r + kbu_cb_r + ROUND;

      // href_sr[1] is href aligned with the stage-2 sums; blank outside lines
      if (!href_sr[1]) begin
        post_img_R <= '0;
        post_img_G <= '0;
        post_img_B <= '0;
      end else begin
        post_img_R <= clamp8(r_sum);
        post_img_G <= clamp8(g_sum);
        post_img_B <= clamp8(b_sum);
      end

      vsync_sr <= {vsync_sr[1:0], per_frame_vsync};
      href_sr  <= {href_sr[1:0],  per_frame_href};
      clken_sr <= {clken_sr[1:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_sr[2];
  assign post_frame_href  = href_sr[2];
  assign post_frame_clken = clken_sr[2];
  assign post_img_RGB565  = {post_img_R[7:3], post_img_G[7:2], post_img_B[7:3]};

endmodule

// File: tb/tb_image_ycbcr444_rgb888.sv
// Bench for image_ycbcr444_rgb888: directed vectors, sync alignment, random lines, mid-line reset.
// Honours YCBCR_FULL_RANGE_EN to select the matching reference coefficients and vectors.
module tb_image_ycbcr444_rgb888;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        per_frame_vsync, per_frame_href, per_frame_clken;
  logic [7:0]  per_img_Y, per_img_Cb, per_img_Cr;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0]  post_img_R, post_img_G, post_img_B;
  logic [15:0] post_img_RGB565;

  int checks = 0;
  int failures = 0;

  // Entry layout: {vsync, href, clken, R, G, B}
  logic [26:0] exp_q[$];

  image_ycbcr444_rgb888 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_Y        (per_img_Y),
    .per_img_Cb       (per_img_Cb),
    .per_img_Cr       (per_img_Cr),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_R       (post_img_R),
    .post_img_G       (post_img_G),
    .post_img_B       (post_img_B),
    .post_img_RGB565  (post_img_RGB565)
  );

  always #5 clk = ~clk;

  function automatic int clip(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Reference: fixed-point colour matrix with rounding, floor division by 512, clamp
  function automatic logic [23:0] model_rgb(input int y, input int cb, input int cr);
    int ky, krv, kgu, kgv, kbu, yy, cbb, crr, r, g, b;
`ifdef YCBCR_FULL_RANGE_EN
    ky = 512; krv = 718; kgu = 176; kgv = 366; kbu = 907; yy = y;
`else
    ky = 596; krv = 817; kgu = 201; kgv = 416; kbu = 1033; yy = y - 16;
`endif
    cbb = cb - 128;
    crr = cr - 128;
    r = (ky * yy + krv * crr + 256) >>> 9;
    g = (ky * yy - kgu * cbb - kgv * crr + 256) >>> 9;
    b = (ky * yy + kbu * cbb + 256) >>> 9;
    return {8'(clip(r)), 8'(clip(g)), 8'(clip(b))};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vsync"}, 16'(post_frame_vsync), 16'd0);
    check({tag, "_href"},  16'(post_frame_href),  16'd0);
    check({tag, "_clken"}, 16'(post_frame_clken), 16'd0);
    check({tag, "_R"},     16'(post_img_R),       16'd0);
    check({tag, "_G"},     16'(post_img_G),       16'd0);
    check({tag, "_B"},     16'(post_img_B),       16'd0);
    check({tag, "_565"},   post_img_RGB565,       16'd0);
  endtask

  // One clock: check the output due now, then apply new inputs and queue their expectation
  task automatic step_exp(input logic vs, input logic hr, input logic ce,
                          input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                          input logic [23:0] rgb);
    logic [26:0] e;
    logic [7:0]  er, eg, eb;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL queue_underflow observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      {er, eg, eb} = e[23:0];
      check("vsync", 16'(post_frame_vsync), 16'(e[26]));
      check("href",  16'(post_frame_href),  16'(e[25]));
      check("clken", 16'(post_frame_clken), 16'(e[24]));
      if (!e[25] || e[24]) begin
        check("R",      16'(post_img_R), 16'(er));
        check("G",      16'(post_img_G), 16'(eg));
        check("B",      16'(post_img_B), 16'(eb));
        check("RGB565", post_img_RGB565, {er[7:3], eg[7:2], eb[7:3]});
      end
    end
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_Y       = y;
    per_img_Cb      = cb;
    per_img_Cr      = cr;
    exp_q.push_back({vs, hr, ce, (hr ? rgb : 24'd0)});
  endtask

  task automatic step(input logic vs, input logic hr, input logic ce,
                      input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    step_exp(vs, hr, ce, y, cb, cr, model_rgb(int'(y), int'(cb), int'(cr)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) exp_q.push_back(27'd0);
  endtask

  initial begin
    int len;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_Y  = 8'd0;
    per_img_Cb = 8'd0;
    per_img_Cr = 8'd0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    release_reset();
    idle(3);

    // Directed vectors with known results
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);
`ifdef YCBCR_FULL_RANGE_EN
    step_exp(1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128, {8'd128, 8'd128, 8'd128});
    step_exp(1'b0, 1'b1, 1'b1, 8'd0,   8'd128, 8'd128, {8'd0,   8'd0,   8'd0});
    step_exp(1'b0, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128, {8'd255, 8'd255, 8'd255});
`else
    step_exp(1'b0, 1'b1, 1'b1, 8'd16,  8'd128, 8'd128, {8'd0,   8'd0,   8'd0});
    step_exp(1'b0, 1'b1, 1'b1, 8'd235, 8'd128, 8'd128, {8'd255, 8'd255, 8'd255});
    step_exp(1'b0, 1'b1, 1'b1, 8'd81,  8'd90,  8'd240, {8'd254, 8'd0,   8'd0});
    step_exp(1'b0, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, {8'd255, 8'd125, 8'd255});
    step_exp(1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   {8'd0,   8'd136, 8'd0});
`endif
    idle(4);

    // Sync alignment: vsync pulse, 8-pixel line with clken toggling
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'((i % 2) == 0), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle(5);

    // Random lines separated by one-cycle href gaps, random clken gaps
    for (int ln = 0; ln < 6; ln++) begin
      len = $urandom_range(10, 30);
      for (int i = 0; i < len; i++)
        step(1'b0, 1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      step(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)));
    end
    idle(4);

    // Reset asserted mid-line: outputs clear without waiting for a clock
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 8'd200, 8'd60, 8'd200);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_hold");
    release_reset();
    idle(5);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'd200, 8'd60, 8'd200);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
